// File: rtl/sodor_alu_pipe_model.sv
// Cycle-level reference model of an in-order RV32I ALU pipeline (OP / OP-IMM only).
// Depth and hazard policy (full bypass or RAW interlock) are set by parameters.
module sodor_alu_pipe_model #(
  parameter int unsigned STAGES   = 5,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              imem_data,
  input  logic                     imem_valid,
  output logic                     imem_ready,
  output logic [31:0]              port_pc,
  output logic [XLEN*NUM_REGS-1:0] port_regfile,
  output logic                     port_wb_valid,
  output logic [4:0]               port_wb_addr,
  output logic [XLEN-1:0]          port_wb_data,
  output logic                     port_stall,
  output logic                     port_illegal,
  output logic [31:0]              port_retired
);

  localparam int unsigned LAST    = STAGES - 1;
  localparam logic [6:0]  OPC_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_REG = 7'b0110011;

  logic [STAGES-1:0] valid_q;
  logic [31:0]       inst0_q;
  logic [31:0]       inst1_q;
  logic [4:0]        rd_q  [2:LAST];
  logic [XLEN-1:0]   res_q [2:LAST];
  logic [XLEN-1:0]   rf_q  [NUM_REGS];
  logic [31:0]       pc_q;
  logic [31:0]       retired_q;
  logic              illegal_q;

  logic [4:0]        stg_rd [1:LAST];
  logic              stall;
  logic              accept;
  logic              legal;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic              ex_is_imm;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   src_b;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        shamt;
  logic [XLEN-1:0]   alu_res;

  always_comb begin
    stg_rd[1] = inst1_q[11:7];
    for (int unsigned k = 2; k <= LAST; k++) begin
      stg_rd[k] = rd_q[k];
    end
  end

  // Interlock: the decode-stage instruction waits until every producer has
  // reached WB, so its regfile read in EXE sees the written value.
  always_comb begin
    stall = 1'b0;
    if (FWD_EN == 0 && valid_q[0]) begin
      for (int unsigned k = 1; k <= LAST - 1; k++) begin
        if (valid_q[k] && stg_rd[k] != 5'd0 &&
            (stg_rd[k] == inst0_q[19:15] ||
             (inst0_q[5] && stg_rd[k] == inst0_q[24:20]))) begin
          stall = 1'b1;
        end
      end
    end
  end

  assign imem_ready = reset_n && !stall;
  assign accept     = imem_valid && imem_ready;
  assign legal      = (imem_data[6:0] == OPC_IMM) || (imem_data[6:0] == OPC_REG);

  assign ex_rs1    = inst1_q[19:15];
  assign ex_rs2    = inst1_q[24:20];
  assign ex_is_imm = (inst1_q[6:0] == OPC_IMM);
  assign ex_imm    = {{(XLEN-12){inst1_q[31]}}, inst1_q[31:20]};

  // Descending scan lets the youngest matching stage override older ones.
  always_comb begin
    op_a = (ex_rs1 == 5'd0) ? '0 : rf_q[ex_rs1];
    op_b = (ex_rs2 == 5'd0) ? '0 : rf_q[ex_rs2];
    if (FWD_EN != 0) begin
      for (int unsigned k = LAST; k >= 2; k--) begin
        if (valid_q[k] && ex_rs1 != 5'd0 && rd_q[k] == ex_rs1) op_a = res_q[k];
        if (valid_q[k] && ex_rs2 != 5'd0 && rd_q[k] == ex_rs2) op_b = res_q[k];
      end
    end
  end

  assign src_b = ex_is_imm ? ex_imm : op_b;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_res = '0;
    unique case (inst1_q[14:12])
      3'b000: alu_res = (!ex_is_imm && inst1_q[30]) ? op_a - src_b : op_a + src_b;
      3'b001: alu_res = op_a << shamt;
      3'b010: alu_res[0] = ($signed(op_a) < $signed(src_b));
      3'b011: alu_res[0] = (op_a < src_b);
      3'b100: alu_res = op_a ^ src_b;
      3'b101: alu_res = inst1_q[30] ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
      3'b110: alu_res = op_a | src_b;
      3'b111: alu_res = op_a & src_b;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      inst0_q   <= '0;
      inst1_q   <= '0;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      illegal_q <= 1'b0;
      for (int unsigned s = 2; s <= LAST; s++) begin
        rd_q[s]  <= '0;
        res_q[s] <= '0;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (valid_q[LAST]) begin
        retired_q <= retired_q + 32'd1;
        if (rd_q[LAST] != 5'd0) rf_q[rd_q[LAST]] <= res_q[LAST];
      end
      for (int unsigned s = 2; s <= LAST; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
      for (int unsigned s = 3; s <= LAST; s++) begin
        rd_q[s]  <= rd_q[s-1];
        res_q[s] <= res_q[s-1];
      end
      rd_q[2]  <= inst1_q[11:7];
      res_q[2] <= alu_res;
      if (stall) begin
        valid_q[1] <= 1'b0;
      end else begin
        valid_q[1] <= valid_q[0];
        inst1_q    <= inst0_q;
        valid_q[0] <= accept && legal;
        inst0_q    <= imem_data;
      end
      illegal_q <= accept && !legal;
      if (accept) pc_q <= pc_q + 32'd4;
    end
  end

  always_comb begin
    port_regfile = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      port_regfile[XLEN*i +: XLEN] = rf_q[i];
    end
  end

  assign port_wb_valid = valid_q[LAST];
  assign port_wb_addr  = valid_q[LAST] ? rd_q[LAST] : '0;
  assign port_wb_data  = valid_q[LAST] ? res_q[LAST] : '0;
  assign port_stall    = stall;
  assign port_illegal  = illegal_q;
  assign port_retired  = retired_q;
  assign port_pc       = pc_q;

endmodule

// File: tb/tb_sodor_alu_pipe_model.sv
// Bench for sodor_alu_pipe_model: one bypass and one interlock instance, checked
// against an in-order architectural model that executes each word at accept.
module tb_sodor_alu_pipe_model;
  localparam int unsigned STAGES = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        sel;

  logic         rdy_f, wbv_f, stall_f, ill_f, rdy_s, wbv_s, stall_s, ill_s;
  logic [31:0]  pc_f, wbd_f, ret_f, pc_s, wbd_s, ret_s;
  logic [4:0]   wba_f, wba_s;
  logic [1023:0] rf_f, rf_s;

  sodor_alu_pipe_model #(.STAGES(STAGES), .FWD_EN(1)) dut_fwd (
    .clk(clk), .reset_n(reset_n), .imem_data(imem_data),
    .imem_valid(imem_valid && !sel), .imem_ready(rdy_f), .port_pc(pc_f),
    .port_regfile(rf_f), .port_wb_valid(wbv_f), .port_wb_addr(wba_f),
    .port_wb_data(wbd_f), .port_stall(stall_f), .port_illegal(ill_f),
    .port_retired(ret_f));

  sodor_alu_pipe_model #(.STAGES(STAGES), .FWD_EN(0)) dut_stl (
    .clk(clk), .reset_n(reset_n), .imem_data(imem_data),
    .imem_valid(imem_valid && sel), .imem_ready(rdy_s), .port_pc(pc_s),
    .port_regfile(rf_s), .port_wb_valid(wbv_s), .port_wb_addr(wba_s),
    .port_wb_data(wbd_s), .port_stall(stall_s), .port_illegal(ill_s),
    .port_retired(ret_s));

  logic rdy, wbv, stall, ill;
  logic [31:0] pc, wbd, ret;
  logic [4:0] wba;
  logic [1023:0] rf;
  assign rdy   = sel ? rdy_s   : rdy_f;
  assign wbv   = sel ? wbv_s   : wbv_f;
  assign stall = sel ? stall_s : stall_f;
  assign ill   = sel ? ill_s   : ill_f;
  assign pc    = sel ? pc_s    : pc_f;
  assign wbd   = sel ? wbd_s   : wbd_f;
  assign ret   = sel ? ret_s   : ret_f;
  assign wba   = sel ? wba_s   : wba_f;
  assign rf    = sel ? rf_s    : rf_f;

  typedef struct { logic [4:0] rd; logic [31:0] data; int due; } wb_t;
  wb_t exp_q[$];
  logic [31:0] mreg [32];
  logic [31:0] m_pc, m_ret;
  int cyc, stall_cnt, ill_cnt, n_cmp, n_bad;
  bit ill_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    return rf[32*i +: 32];
  endfunction

  function automatic logic [31:0] ref_exec(input logic [31:0] w, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] y;
    logic [4:0]  sh;
    logic        is_r;
    is_r = (w[6:0] == 7'b0110011);
    y    = is_r ? b : {{20{w[31]}}, w[31:20]};
    sh   = y[4:0];
    case (w[14:12])
      3'd0: return (is_r && w[30]) ? a - y : a + y;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (a < y) ? 32'd1 : 32'd0;
      3'd4: return a ^ y;
      3'd5: return w[30] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6: return a | y;
      default: return a & y;
    endcase
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    int k;
    rd  = 5'($urandom_range(7));
    rs1 = 5'($urandom_range(7));
    rs2 = 5'($urandom_range(7));
    f3  = 3'($urandom);
    imm = 12'($urandom);
    k   = $urandom_range(15);
    if (k == 0) begin
      w = $urandom;
      if (w[6:0] == 7'b0010011 || w[6:0] == 7'b0110011) w[6:0] = 7'b0000011;
      return w;
    end
    if (k == 1) return 32'h00000013;
    if (k < 9) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(1) == 1) ? 7'h20 : 7'h00;
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
    end
    if (f3 == 3'd1) imm[11:5] = 7'h00;
    else if (f3 == 3'd5) imm[11:5] = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // One cycle: check outputs at the falling edge, update the model on accept.
  task automatic step(output bit acc);
    wb_t e;
    logic [31:0] w, r;
    acc = 1'b0;
    @(negedge clk);
    if (!reset_n) begin
      chk("ready_in_reset", rdy, 0);
    end else begin
      acc = imem_valid && rdy;
      chk("illegal_pulse", ill, ill_exp);
      if (!sel) chk("fwd_stall_ready", {stall, rdy}, 2'b01);
      else chk("ready_vs_stall", rdy, !stall);
      if (stall) stall_cnt++;
      if (ill) ill_cnt++;
      if (wbv) begin
        if (exp_q.size() == 0) chk("wb_unexpected", wbv, 0);
        else begin
          e = exp_q.pop_front();
          chk("wb_addr", wba, e.rd);
          chk("wb_data", wbd, e.data);
          if (!sel) chk("wb_cycle", cyc, e.due);
        end
      end
      ill_exp = 1'b0;
      if (acc) begin
        w = imem_data;
        m_pc += 4;
        if (w[6:0] == 7'b0010011 || w[6:0] == 7'b0110011) begin
          r = ref_exec(w, mreg[w[19:15]], mreg[w[24:20]]);
          if (w[11:7] != 5'd0) mreg[w[11:7]] = r;
          m_ret++;
          exp_q.push_back('{rd: w[11:7], data: r, due: (sel ? -1 : cyc + int'(STAGES))});
        end else ill_exp = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] w);
    bit acc;
    acc = 1'b0;
    imem_data  = w;
    imem_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(acc);
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    imem_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    imem_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      imem_data = $urandom;
      step(acc);
    end
  endtask

  task automatic reset_to(input logic s);
    bit acc;
    reset_n    = 1'b0;
    imem_valid = 1'b0;
    sel        = s;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    m_pc = '0; m_ret = '0; ill_exp = 1'b0; stall_cnt = 0; ill_cnt = 0;
    exp_q.delete();
    step(acc);
    step(acc);
    reset_n = 1'b1;
  endtask

  task automatic final_check(input string tag);
    idle(STAGES + 6);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_retired"}, ret, m_ret);
    chk({tag, "_pc"}, pc, m_pc);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_x%0d", tag, i), dut_reg(i), mreg[i]);
  endtask

  initial begin
    bit acc;
    n_cmp = 0; n_bad = 0; cyc = 0;
    imem_valid = 1'b0; imem_data = '0; sel = 1'b0; reset_n = 1'b0;
    #1;

    reset_to(1'b0);
    chk("reset_pc", pc, 0);
    chk("reset_retired", ret, 0);
    issue(32'h00500093);
    idle(8);
    chk("t1_x1", dut_reg(1), 5);
    chk("t1_retired", ret, 1);
    chk("t1_pc", pc, 4);

    reset_to(1'b0);
    issue(32'h00500093);
    issue(32'h00108133);
    idle(8);
    chk("t2_x2", dut_reg(2), 10);
    chk("t2_retired", ret, 2);

    reset_to(1'b1);
    issue(32'h00500093);
    issue(32'h00108133);
    idle(8);
    chk("t3_stall_cycles", stall_cnt, 3);
    chk("t3_x2", dut_reg(2), 10);
    chk("t3_pc", pc, 8);

    reset_to(1'b0);
    issue(32'hFF000193);
    issue(32'h4021D213);
    issue(32'h01C1D293);
    idle(8);
    chk("t4_x3", dut_reg(3), 32'hFFFFFFF0);
    chk("t4_x4", dut_reg(4), 32'hFFFFFFFC);
    chk("t4_x5", dut_reg(5), 32'h0000000F);

    reset_to(1'b0);
    issue(32'h00000003);
    issue(32'h00700013);
    idle(8);
    chk("t5_illegal_pulses", ill_cnt, 1);
    chk("t5_retired", ret, 1);
    chk("t5_x0", dut_reg(0), 0);

    // Mid-flight reset with the first of three instructions sitting in WB.
    reset_to(1'b0);
    issue(32'h00100093);
    issue(32'h00200113);
    issue(32'h00300193);
    idle(2);
    #1;
    chk("t6_wb_before", wbv, 1);
    chk("t6_pc_before", pc, 12);
    reset_n = 1'b0;
    #1;
    chk("t6_wb_cleared", wbv, 0);
    chk("t6_pc_cleared", pc, 0);
    chk("t6_ready_low", rdy, 0);
    chk("t6_retired", ret, 0);
    chk("t6_x1", dut_reg(1), 0);
    reset_to(1'b0);
    idle(12);
    chk("t6_no_retire", ret, 0);
    chk("t6_x1_after", dut_reg(1), 0);

    for (int m = 0; m < 2; m++) begin
      reset_to(m[0]);
      for (int i = 0; i < 400; i++) begin
        imem_valid = ($urandom_range(3) != 0);
        imem_data  = gen_inst();
        step(acc);
      end
      imem_valid = 1'b0;
      final_check(m == 0 ? "rnd_fwd" : "rnd_stall");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sodor_alu_pipe_model.md
Name: sodor_alu_pipe_model

Overview:
- Parametrised cycle-level reference model of an in-order Sodor-style integer pipeline for RV32I ALU instructions.
- Covers both the OP-IMM (0010011) and OP (0110011) classes.
- Tracks architectural state (regfile, pc) and per-stage valid/instruction registers.
- Stage count and forwarding mode are configurable; RAW hazards are resolved by full bypass or by stalling.
- Used as the abstract side of refinement checks against the Sodor RTL.

Parameters:
- STAGES, 5, pipeline depth; stage 0 = DEC, stage 1 = EXE, stage STAGES-1 = WB; legal range 3..8.
- FWD_EN, 1, 1 = full operand bypass; 0 = interlock (stall) on RAW.
- XLEN, 32, data width; only 32 is supported.
- NUM_REGS, 32, architectural register count.
- RESET_PC, 32'h0, pc value after reset.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_data  in  32  instruction word.
- imem_valid  in  1  instruction offered.
- imem_ready  out  1  model can accept; low while stalled.
- port_pc  out  32  address of next instruction to accept.
- port_regfile  out  XLEN*NUM_REGS  flattened regfile, reg i at bits [XLEN*i+XLEN-1 : XLEN*i].
- port_wb_valid  out  1  an instruction retires this cycle.
- port_wb_addr  out  5  rd of the retiring instruction.
- port_wb_data  out  32  result of the retiring instruction.
- port_stall  out  1  RAW interlock active.
- port_illegal  out  1  one-cycle pulse: accepted word not OP/OP-IMM.
- port_retired  out  32  count of retired instructions, wraps at 2^32.

Behaviour:
- Reset (reset_n low, asynchronous): regfile = 0, pc = RESET_PC, all stage valids = 0, retired = 0, wb_valid/illegal/stall = 0.
  - Asserting reset mid-flight discards every in-flight instruction; no writeback occurs for them.
  - imem_ready = 0 during reset.
- Accept:
  - Accept occurs when imem_valid && imem_ready; pc += 4 on each accept.
  - A legal word enters stage 0 valid. Any other opcode enters as a bubble (valid = 0) and pulses port_illegal in the following cycle.
  - No accept: a bubble enters stage 0, unless stalled.
- Advance: when not stalled, every stage s moves to s+1. An instruction accepted at edge T occupies stage s during cycle T+s.
- Execute, in stage 1:
  - ALU result is computed once and carried down the pipe to WB.
  - I-type imm = sign-extended inst[31:20]; shifts use the low 5 bits of imm or rs2.
  - SUB/SRA/SRAI are selected by inst[30]. SRA is a true arithmetic shift.
  - SLT/SLTI are signed compares; SLTU/SLTIU are unsigned.
- Operand source, FWD_EN=1: the youngest older valid stage k in 2..STAGES-1 whose rd equals rs (rs != 0) supplies the value; otherwise the regfile. Never stalls.
- Interlock, FWD_EN=0:
  - Stall while the valid stage-0 instruction has rs1, or rs2 for R-type, nonzero and equal to the rd of any valid stage in 1..STAGES-2.
  - During a stall: stage 0 and pc hold, a bubble enters stage 1, imem_ready = 0, port_stall = 1.
  - Operands are then read from the regfile in stage 1.
- Writeback: valid stage STAGES-1 sets wb_valid/wb_addr/wb_data combinationally from that stage.
  - At the edge ending the cycle, regfile[rd] is written if rd != 0, and retired += 1.
  - x0 reads 0 always. NOP (0x00000013) is legal and retires with no effect.
- Bubbles never write, never count, and never match in hazard or bypass checks.
- No flushes exist: no branches are modelled; illegal words become bubbles.

Test Plan:
- STAGES=5, FWD_EN=1. Accept 0x00500093 (addi x1,x0,5) at edge T, then idle -> wb_valid in cycle T+4 with wb_addr=1, wb_data=5. x1=5 after that edge; retired=1; pc=4.
- FWD_EN=1. Back-to-back 0x00500093, 0x00108133 (add x2,x1,x1) -> imem_ready never drops; x2=10; retired=2.
- FWD_EN=0, STAGES=5. Same pair -> port_stall high for exactly 3 cycles with imem_ready low. x2=10; pc=8 at end.
- Shift ops, each result checked at wb:
  - 0xFF000193 (addi x3,x0,-16) -> x3=0xFFFFFFF0
  - 0x4021D213 (srai x4,x3,2) -> x4=0xFFFFFFFC
  - 0x01C1D293 (srli x5,x3,28) -> x5=0x0000000F
- Accept 0x00000003 -> port_illegal pulses once, no retire. Then 0x00700013 (addi x0,x0,7) -> retires with wb_addr=0; regfile[0] stays 0; retired=1.
- Drop reset_n mid-pipe with 3 valid instructions -> outputs clear without a clock edge; pc=RESET_PC. After release, no wb_valid occurs for the discarded instructions.
